wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter between pipeline write-back and a long-latency result buffer
module wb_port_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_reg_from_wb,
  input  logic [4:0]  rd_from_wb,
  input  logic [31:0] data_write_from_wb,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        stall_from_arb,
  output logic [31:0] lu_pending
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [1:0]       LIMIT_C  = 2'(STARVE_LIMIT);

  // Result buffer storage (data path only, not reset)
  logic [4:0]  rd_mem_q   [FIFO_DEPTH];
  logic [31:0] data_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       starve_q, starve_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  // Number of buffered entries per destination register; handles duplicate rd
  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];

  logic        fifo_empty;
  logic        pipe_valid;
  logic        push;
  logic        pop;
  logic        grant_pipe;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign fifo_empty     = (count_q == CNT_ZERO);
  assign lu_ready       = (count_q < DEPTH_C);
  assign stall_from_arb = (starve_q == LIMIT_C);
  assign pipe_valid     = write_reg_from_wb && (rd_from_wb != 5'd0);
  assign head_rd        = rd_mem_q[head_q];
  assign head_data      = data_mem_q[head_q];

  // x0 results complete the handshake but never occupy a buffer slot
  assign push       = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign pop        = !fifo_empty && (stall_from_arb || !pipe_valid);
  assign grant_pipe = pipe_valid && !stall_from_arb;

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

  // Next-state: pointers, occupancy, starvation counter, write port, pending counts
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    for (int r = 0; r < 32; r++) begin
      pend_d[r] = pend_q[r];
    end

    if (push) begin
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_ONE;
    end
    if (pop) begin
      head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_ONE;
    end

    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end

    if (fifo_empty || pop) begin
      starve_d = 2'd0;
    end else if (starve_q != LIMIT_C) begin
      starve_d = starve_q + 2'd1;
    end

    if (pop) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = head_rd;
      rf_wdata_d = head_data;
    end else if (grant_pipe) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = rd_from_wb;
      rf_wdata_d = data_write_from_wb;
    end

    for (int r = 1; r < 32; r++) begin
      if (push && (lu_rd == 5'(r))) begin
        pend_d[r] = pend_d[r] + CNT_ONE;
      end
      if (pop && (head_rd == 5'(r))) begin
        pend_d[r] = pend_d[r] - CNT_ONE;
      end
    end
  end

  // State registers with synchronous reset; reset drops all buffered results
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      starve_q   <= 2'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
      for (int r = 0; r < 32; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      for (int r = 0; r < 32; r++) begin
        pend_q[r] <= pend_d[r];
      end
    end
  end

  // Buffer write at the tail on an accepted, non-x0 result
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      rd_mem_q[tail_q]   <= lu_rd;
      data_mem_q[tail_q] <= lu_data;
    end
  end

  // Pending flags follow the per-register counts; x0 is never pending
  always_comb begin
    lu_pending = 32'd0;
    for (int r = 1; r < 32; r++) begin
      lu_pending[r] = (pend_q[r] != CNT_ZERO);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed table-driven bench for wb_port_arbiter
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        write_reg_from_wb;
  logic [4:0]  rd_from_wb;
  logic [31:0] data_write_from_wb;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        stall_from_arb;
  logic [31:0] lu_pending;

  int checks;
  int errors;

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .write_reg_from_wb  (write_reg_from_wb),
    .rd_from_wb         (rd_from_wb),
    .data_write_from_wb (data_write_from_wb),
    .lu_valid           (lu_valid),
    .lu_rd              (lu_rd),
    .lu_data            (lu_data),
    .lu_ready           (lu_ready),
    .rf_we              (rf_we),
    .rf_rd              (rf_rd),
    .rf_wdata           (rf_wdata),
    .stall_from_arb     (stall_from_arb),
    .lu_pending         (lu_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        luv;
    logic [4:0]  lurd;
    logic [31:0] lud;
    logic        e_ready;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int r, int wr, int rd, int wd, int luv, int lurd, int lud,
                              int e_ready, int e_stall, int e_we, int e_rd, int e_wd, int e_pend);
    vec_t v;
    v.rst = 1'(r);      v.wr = 1'(wr);       v.rd = 5'(rd);     v.wd = 32'(wd);
    v.luv = 1'(luv);    v.lurd = 5'(lurd);   v.lud = 32'(lud);
    v.e_ready = 1'(e_ready); v.e_stall = 1'(e_stall);
    v.e_we = 1'(e_we);  v.e_rd = 5'(e_rd);   v.e_wd = 32'(e_wd); v.e_pend = 32'(e_pend);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic wr, input logic [4:0] rd, input logic [31:0] wd,
                       input logic luv, input logic [4:0] lurd, input logic [31:0] lud);
    rst = r;
    write_reg_from_wb = wr;
    rd_from_wb = rd;
    data_write_from_wb = wd;
    lu_valid = luv;
    lu_rd = lurd;
    lu_data = lud;
  endtask

  initial begin
    int first_stall;
    int second_stall;
    int pipe_idx;
    logic stalled;

    checks = 0;
    errors = 0;

    // idle lines
    vq.push_back(mk(0,1,5,'hDEADBEEF,0,0,0,      1,0, 1,5,'hDEADBEEF,0));
    vq.push_back(mk(0,0,0,0,0,0,0,               1,0, 0,5,'hDEADBEEF,0));
    vq.push_back(mk(0,1,3,'h22,1,7,'h11,         1,0, 1,3,'h22,1<<7));
    vq.push_back(mk(0,0,0,0,0,0,0,               1,0, 1,7,'h11,0));
    vq.push_back(mk(0,0,0,0,0,0,0,               1,0, 0,7,'h11,0));
    vq.push_back(mk(0,1,0,'h55,1,0,'h99,         1,0, 0,7,'h11,0));
    vq.push_back(mk(0,0,0,0,0,0,0,               1,0, 0,7,'h11,0));
    vq.push_back(mk(0,1,1,'hA1,1,10,'h100,       1,0, 1,1,'hA1,1<<10));
    vq.push_back(mk(0,1,2,'hA2,1,11,'h101,       1,0, 1,2,'hA2,(1<<10)|(1<<11)));
    vq.push_back(mk(0,1,4,'hA4,1,12,'h102,       0,0, 1,4,'hA4,(1<<10)|(1<<11)));
    vq.push_back(mk(0,0,0,0,1,12,'h102,          0,0, 1,10,'h100,1<<11));
    vq.push_back(mk(0,0,0,0,1,12,'h102,          1,0, 1,11,'h101,1<<12));
    vq.push_back(mk(0,0,0,0,1,13,'h103,          1,0, 1,12,'h102,1<<13));
    vq.push_back(mk(0,0,0,0,0,0,0,               1,0, 1,13,'h103,0));
    vq.push_back(mk(0,0,0,0,0,0,0,               1,0, 0,13,'h103,0));
    vq.push_back(mk(0,1,1,'hB1,1,20,'h200,       1,0, 1,1,'hB1,1<<20));
    vq.push_back(mk(0,1,2,'hB2,1,20,'h201,       1,0, 1,2,'hB2,1<<20));
    vq.push_back(mk(0,0,0,0,0,0,0,               0,0, 1,20,'h200,1<<20));
    vq.push_back(mk(0,0,0,0,0,0,0,               1,0, 1,20,'h201,0));
    vq.push_back(mk(0,1,1,'hC1,1,21,'h300,       1,0, 1,1,'hC1,1<<21));
    vq.push_back(mk(0,1,2,'hC2,1,22,'h301,       1,0, 1,2,'hC2,(1<<21)|(1<<22)));
    vq.push_back(mk(1,1,3,'hC3,1,23,'h302,       0,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,               1,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,               1,0, 0,0,0,0));

    drive(1'b1, 1'b1, 5'd9, 32'h1234, 1'b1, 5'd9, 32'h5678);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("reset_we",    32'(rf_we), 32'd0);
    chk("reset_rd",    32'(rf_rd), 32'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_pend",  lu_pending, 32'd0);
    chk("reset_ready", 32'(lu_ready), 32'd1);
    chk("reset_stall", 32'(stall_from_arb), 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].wr, vq[i].rd, vq[i].wd, vq[i].luv, vq[i].lurd, vq[i].lud);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(lu_ready), 32'(vq[i].e_ready));
      chk($sformatf("v%0d_stall", i), 32'(stall_from_arb), 32'(vq[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i),    32'(rf_we), 32'(vq[i].e_we));
      chk($sformatf("v%0d_rd", i),    32'(rf_rd), 32'(vq[i].e_rd));
      chk($sformatf("v%0d_wdata", i), rf_wdata, vq[i].e_wd);
      chk($sformatf("v%0d_pend", i),  lu_pending, vq[i].e_pend);
    end

    // Starvation: two buffered results while the pipeline writes every cycle
    first_stall = -1;
    second_stall = -1;
    pipe_idx = 1;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b1, 5'(pipe_idx), 32'hD000_0000 + 32'(pipe_idx),
            (c < 2), (c == 0) ? 5'd8 : 5'd9, (c == 0) ? 32'h800 : 32'h900);
      @(negedge clk);
      if (c == 2) chk("starve_full_ready", 32'(lu_ready), 32'd0);
      stalled = stall_from_arb;
      if (stalled) begin
        if (first_stall < 0) first_stall = c;
        else if (second_stall < 0) second_stall = c;
      end
      @(posedge clk);
      #1;
      if (stalled) begin
        chk($sformatf("starve_c%0d_we", c), 32'(rf_we), 32'd1);
        chk($sformatf("starve_c%0d_rd", c), 32'(rf_rd), (first_stall == c) ? 32'd8 : 32'd9);
        chk($sformatf("starve_c%0d_wdata", c), rf_wdata, (first_stall == c) ? 32'h800 : 32'h900);
        chk($sformatf("starve_c%0d_pend", c), lu_pending, (first_stall == c) ? 32'(1 << 9) : 32'd0);
      end else begin
        chk($sformatf("pipe_c%0d_rd", c), 32'(rf_rd), 32'(pipe_idx));
        chk($sformatf("pipe_c%0d_wdata", c), rf_wdata, 32'hD000_0000 + 32'(pipe_idx));
        pipe_idx++;
      end
    end
    chk("first_stall_cycle", 32'(first_stall), 32'd4);
    chk("second_stall_cycle", 32'(second_stall), 32'd8);
    chk("starve_end_pend", lu_pending, 32'd0);
    chk("starve_end_ready", 32'(lu_ready), 32'd1);

    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
